// File: rtl/rvvi_trace_encoder.sv
// Captures per-retirement RVVI records into a small FIFO and serializes each
// into a framed stream of 32-bit words (header, insn, pc, optional rd/csr).
module rvvi_trace_encoder #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_trap,
    input  logic [1:0]      in_mode,
    input  logic            in_rd_wb,
    input  logic [4:0]      in_rd_idx,
    input  logic [XLEN-1:0] in_rd_data,
    input  logic            in_csr_wb,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_csr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_last,
    output logic            overflow,
    output logic [15:0]     drop_count
);

    localparam int unsigned W  = XLEN / 32;
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0]      seq;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [1:0]      mode;
        logic            rd_wb;
        logic [4:0]      rd_idx;
        logic [XLEN-1:0] rd_data;
        logic            csr_wb;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
    } rec_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        INSN,
        PC,
        RD,
        CSRA,
        CSRD
    } state_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    rec_t          rec_in;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    seq;
    state_t        state;
    state_t        state_nx;
    logic          sub;
    logic          sub_nx;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          out_fire;
    logic          is_last;
    logic          last_sub;
    logic          more_queued;
    logic [3:0]    n_words;
    logic [31:0]   hdr_word;

    function automatic logic [31:0] pick(input logic [XLEN-1:0] v, input logic s);
        logic [XLEN-1:0] t;
        t = v >> {s, 5'd0};
        return t[31:0];
    endfunction

    assign full     = (count == (PW+1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign drop     = in_valid && full;
    assign head     = mem[rd_ptr];
    assign out_fire = out_valid && out_ready;
    assign pop      = out_fire && is_last;
    assign last_sub = (sub == 1'(W - 1));
    // A record pushed during the final-word handshake still counts as queued.
    assign more_queued = (count != (PW+1)'(1)) || push;

    assign rec_in = '{
        seq:      seq,
        insn:     in_insn,
        pc:       in_pc,
        trap:     in_trap,
        mode:     in_mode,
        rd_wb:    in_rd_wb,
        rd_idx:   in_rd_idx,
        rd_data:  in_rd_data,
        csr_wb:   in_csr_wb,
        csr_addr: in_csr_addr,
        csr_data: in_csr_data
    };

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            state      <= IDLE;
            sub        <= 1'b0;
        end else begin
            if (in_valid) begin
                seq <= seq + 8'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            state <= state_nx;
            sub   <= sub_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sub_nx   = sub;
        is_last  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_nx = HDR;
            end
            HDR: begin
                if (out_fire) state_nx = INSN;
            end
            INSN: begin
                if (out_fire) begin
                    state_nx = PC;
                    sub_nx   = 1'b0;
                end
            end
            PC: begin
                is_last = last_sub && !head.rd_wb && !head.csr_wb;
                if (out_fire) begin
                    if (!last_sub) begin
                        sub_nx = sub + 1'b1;
                    end else begin
                        sub_nx = 1'b0;
                        if (head.rd_wb)       state_nx = RD;
                        else if (head.csr_wb) state_nx = CSRA;
                        else                  state_nx = more_queued ? HDR : IDLE;
                    end
                end
            end
            RD: begin
                is_last = last_sub && !head.csr_wb;
                if (out_fire) begin
                    if (!last_sub) begin
                        sub_nx = sub + 1'b1;
                    end else begin
                        sub_nx = 1'b0;
                        if (head.csr_wb) state_nx = CSRA;
                        else             state_nx = more_queued ? HDR : IDLE;
                    end
                end
            end
            CSRA: begin
                if (out_fire) begin
                    state_nx = CSRD;
                    sub_nx   = 1'b0;
                end
            end
            CSRD: begin
                is_last = last_sub;
                if (out_fire) begin
                    if (!last_sub) begin
                        sub_nx = sub + 1'b1;
                    end else begin
                        sub_nx   = 1'b0;
                        state_nx = more_queued ? HDR : IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        n_words = 4'd1 + 4'(W)
                + (head.rd_wb  ? 4'(W)        : 4'd0)
                + (head.csr_wb ? 4'd1 + 4'(W) : 4'd0);
        hdr_word = {8'hA5, head.seq, n_words, head.trap, head.mode,
                    head.rd_wb, head.csr_wb, 2'b00,
                    head.rd_wb ? head.rd_idx : 5'd0};
    end

    always_comb begin
        out_data = '0;
        case (state)
            HDR:     out_data = hdr_word;
            INSN:    out_data = head.insn;
            PC:      out_data = pick(head.pc, sub);
            RD:      out_data = pick(head.rd_data, sub);
            CSRA:    out_data = {20'b0, head.csr_addr};
            CSRD:    out_data = pick(head.csr_data, sub);
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state != IDLE);
    assign out_last  = is_last;

endmodule
